gate_controller: RTL and testbench

GATE_CONTROLLER -- requirements
Module: gate_controller

---
 rtl/gate_controller.sv | 97 +++++++++
 tb/tb_gate_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_controller.sv
// gate_controller: noise gate with attack/open/hold/release gain ramp and gated audio multiply.
// Define GATE_FLOOR_EN to close to FLOOR_GAIN instead of full mute.
module gate_controller #(
  parameter logic [15:0] THRESH_OPEN  = 16'h0400,
  parameter logic [15:0] THRESH_CLOSE = 16'h0200,
  parameter int          HOLD_SAMPLES = 2400,
  parameter logic [15:0] ATTACK_STEP  = 16'h0100,
  parameter logic [15:0] RELEASE_STEP = 16'h0010,
  parameter logic [15:0] FLOOR_GAIN   = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_en,
  input  logic [15:0] rms_in,
  input  logic [15:0] x_in,
  output logic [15:0] y_out,
  output logic        y_valid,
  output logic [15:0] gain_out,
  output logic        gate_open,
  output logic [2:0]  state_out
);
`ifdef GATE_FLOOR_EN
  localparam logic [15:0] FLOOR = FLOOR_GAIN;
`else
  localparam logic [15:0] FLOOR = FLOOR_GAIN & 16'h0000;
`endif
  localparam int HW = HOLD_SAMPLES > 1 ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [15:0] PEAK = 16'h7FFF;
  typedef enum logic [2:0] {CLOSED = 3'd0, ATTACK = 3'd1, OPEN = 3'd2, HOLD = 3'd3, RELEASE = 3'd4} state_t;
  state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0] gain_q, gain_d, y_q, y_d, up_sat, dn_sat;
  logic valid_q, open_q, open_d, hi, lo;
  logic [16:0] up, dn;
  logic signed [32:0] prod;
  assign hi = rms_in >= THRESH_OPEN;
  assign lo = rms_in < THRESH_CLOSE;
  // 17-bit sums so saturation catches overflow past PEAK and borrow below zero
  assign up = {1'b0, gain_q} + {1'b0, ATTACK_STEP};
  assign dn = {1'b0, gain_q} - {1'b0, RELEASE_STEP};
  assign up_sat = up > {1'b0, PEAK} ? PEAK : up[15:0];
  assign dn_sat = (dn[16] || dn[15:0] < FLOOR) ? FLOOR : dn[15:0];
  assign prod = $signed(x_in) * $signed({1'b0, gain_q});
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gain_d  = gain_q;
    y_d     = y_q;
    if (sample_en) begin
      y_d = 16'(prod >>> 15);
      case (state_q)
        CLOSED: state_d = hi ? ATTACK : CLOSED;
        ATTACK: begin
          gain_d  = lo ? gain_q : up_sat;
          state_d = lo ? RELEASE : (up_sat == PEAK ? OPEN : ATTACK);
        end
        OPEN: begin
          gain_d  = PEAK;
          state_d = !lo ? OPEN : (HOLD_SAMPLES == 0 ? RELEASE : HOLD);
          hold_d  = lo ? HW'(HOLD_SAMPLES - 1) : hold_q;
        end
        HOLD: begin
          state_d = hi ? OPEN : (hold_q == '0 ? RELEASE : HOLD);
          hold_d  = (hi || hold_q == '0) ? hold_q : hold_q - 1'b1;
        end
        RELEASE: begin
          gain_d  = hi ? gain_q : dn_sat;
          state_d = hi ? ATTACK : (dn_sat == FLOOR ? CLOSED : RELEASE);
        end
        default: state_d = CLOSED;
      endcase
    end
    open_d = state_d inside {ATTACK, OPEN, HOLD};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLOSED;
      hold_q  <= '0;
      gain_q  <= FLOOR;
      y_q     <= '0;
      valid_q <= 1'b0;
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gain_q  <= gain_d;
      y_q     <= y_d;
      valid_q <= sample_en;
      open_q  <= open_d;
    end
  end
  assign y_out     = y_q;
  assign y_valid   = valid_q;
  assign gain_out  = gain_q;
  assign gate_open = open_q;
  assign state_out = state_q;
endmodule

// File: tb/tb_gate_controller.sv
// tb_gate_controller: vector table, directed corner sequences and random stimulus against a reference model.
module tb_gate_controller;
`ifdef GATE_FLOOR_EN
  localparam int F = 'h0800;
`else
  localparam int F = 0;
`endif
  localparam int TO = 'h0400, TC = 'h0200, HOLD = 2400, AS = 'h0100, RS = 'h0010;
  logic clk = 0, rst_n = 0, sample_en = 0, y_valid, gate_open;
  logic [15:0] rms_in = 0, x_in = 0, y_out, gain_out;
  logic [2:0] state_out;
  int checks = 0, errors = 0;
  int m_st, m_gain, m_hold, m_v;
  logic [15:0] m_y;

  gate_controller #(
    .THRESH_OPEN(16'h0400), .THRESH_CLOSE(16'h0200), .HOLD_SAMPLES(2400),
    .ATTACK_STEP(16'h0100), .RELEASE_STEP(16'h0010), .FLOOR_GAIN(16'h0800)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .rms_in(rms_in), .x_in(x_in),
    .y_out(y_out), .y_valid(y_valid), .gain_out(gain_out), .gate_open(gate_open), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference: 0=closed 1=attack 2=open 3=hold 4=release; gain in plain integers
  task automatic model(bit r, bit s, int rms, int x);
    int p;
    if (!r) begin
      m_st = 0; m_gain = F; m_hold = 0; m_y = 0; m_v = 0;
      return;
    end
    m_v = s;
    if (!s) return;
    p = $signed(16'(x)) * m_gain;
    m_y = 16'(p >>> 15);
    if (m_st == 0) begin
      if (rms >= TO) m_st = 1;
    end else if (m_st == 1) begin
      if (rms < TC) m_st = 4;
      else begin
        m_gain = (m_gain + AS > 32767) ? 32767 : m_gain + AS;
        if (m_gain == 32767) m_st = 2;
      end
    end else if (m_st == 2) begin
      m_gain = 32767;
      if (rms < TC) begin
        m_st = (HOLD == 0) ? 4 : 3;
        m_hold = HOLD - 1;
      end
    end else if (m_st == 3) begin
      if (rms >= TO) m_st = 2;
      else if (m_hold == 0) m_st = 4;
      else m_hold--;
    end else begin
      if (rms >= TO) m_st = 1;
      else begin
        m_gain = (m_gain - RS < F) ? F : m_gain - RS;
        if (m_gain == F) m_st = 0;
      end
    end
  endtask

  task automatic apply(bit r, bit s, logic [15:0] rms, logic [15:0] x);
    rst_n = r; sample_en = s; rms_in = rms; x_in = x;
    @(posedge clk);
    model(r, s, int'(rms), int'(x));
    #1;
  endtask

  task automatic check_model();
    chk("state", int'(state_out), m_st);
    chk("gain", int'(gain_out), m_gain);
    chk("gate_open", int'(gate_open), int'(m_st >= 1 && m_st <= 3));
    chk("y_valid", int'(y_valid), m_v);
    chk("y_out", int'(y_out), int'(m_y));
  endtask

  task automatic to_open();
    apply(0, 0, 0, 0);
    for (int i = 0; i < 300 && state_out != 3'd2; i++) begin
      apply(1, 1, 16'h0500, 16'($urandom));
      check_model();
    end
    chk("to_open", int'(state_out), 2);
  endtask

  typedef struct {
    bit r; bit s; logic [15:0] rms; logic [15:0] x;
    int st; int gain; int y; bit v;
  } vec_t;
  vec_t tbl[11];

  initial begin
    int n, hold_n;
    logic [15:0] rv[7];
    tbl[0]  = '{0, 0, 16'h0000, 16'h0000, 0, F,         0,               0};
    tbl[1]  = '{1, 1, 16'h0300, 16'h0000, 0, F,         0,               1};
    tbl[2]  = '{1, 0, 16'h0500, 16'h0000, 0, F,         0,               0};
    tbl[3]  = '{1, 1, 16'h0400, 16'h0000, 1, F,         0,               1};
    tbl[4]  = '{1, 1, 16'h0200, 16'h0000, 1, F + 'h100, 0,               1};
    tbl[5]  = '{1, 1, 16'h0500, 16'h4000, 1, F + 'h200, (F + 'h100) >> 1, 1};
    tbl[6]  = '{1, 1, 16'h01FF, 16'h0000, 4, F + 'h200, 0,               1};
    tbl[7]  = '{1, 1, 16'h0300, 16'h0000, 4, F + 'h1F0, 0,               1};
    tbl[8]  = '{1, 1, 16'h0400, 16'h0000, 1, F + 'h1F0, 0,               1};
    tbl[9]  = '{1, 0, 16'h0000, 16'h0000, 1, F + 'h1F0, 0,               0};
    tbl[10] = '{0, 1, 16'h0500, 16'h0000, 0, F,         0,               0};
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].rms, tbl[i].x);
      chk($sformatf("tbl%0d_state", i), int'(state_out), tbl[i].st);
      chk($sformatf("tbl%0d_gain", i), int'(gain_out), tbl[i].gain);
      chk($sformatf("tbl%0d_open", i), int'(gate_open), int'(tbl[i].st >= 1 && tbl[i].st <= 3));
      chk($sformatf("tbl%0d_y", i), int'(y_out), tbl[i].y);
      chk($sformatf("tbl%0d_valid", i), int'(y_valid), int'(tbl[i].v));
    end

    // open ramp, one strobe every 4 cycles
    apply(0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 200 && state_out != 3'd2; i++) begin
      apply(1, 1, 16'h0500, 16'($urandom));
      check_model();
      n++;
      for (int k = 0; k < 3; k++) begin
        apply(1, 0, 16'h0500, 16'($urandom));
        check_model();
      end
    end
    chk("ramp_samples", n, 1 + (32767 - F + 255) / 256);
    chk("ramp_gain", int'(gain_out), 'h7FFF);

    // hold then release down to floor
    hold_n = 0;
    for (int i = 0; i < 8000 && !(state_out == 3'd0 && i > 0); i++) begin
      apply(1, 1, 16'h0100, 16'($urandom));
      check_model();
      if (state_out == 3'd3) hold_n++;
    end
    chk("hold_samples", hold_n, HOLD);
    chk("release_end_state", int'(state_out), 0);
    chk("release_end_gain", int'(gain_out), F);

    // hysteresis band from OPEN and from CLOSED
    to_open();
    for (int i = 0; i < 5000; i++) begin
      apply(1, 1, 16'h0300, 16'($urandom));
      check_model();
    end
    chk("hyst_open_state", int'(state_out), 2);
    chk("hyst_open_gate", int'(gate_open), 1);
    apply(0, 0, 0, 0);
    for (int i = 0; i < 5000; i++) begin
      apply(1, 1, 16'h0300, 16'($urandom));
      check_model();
    end
    chk("hyst_closed_state", int'(state_out), 0);

    // retrigger from HOLD with hold count at 100
    to_open();
    for (int i = 0; i < 2300; i++) begin
      apply(1, 1, 16'h0100, 16'h0000);
      check_model();
    end
    chk("retrig_in_hold", int'(state_out), 3);
    apply(1, 1, 16'h0800, 16'h0000);
    check_model();
    chk("retrig_hold_open", int'(state_out), 2);

    // retrigger from RELEASE at gain 0x4000
    apply(0, 0, 0, 0);
    for (int i = 0; i < 100 && gain_out != 16'h4000; i++) begin
      apply(1, 1, 16'h0500, 16'h0000);
      check_model();
    end
    apply(1, 1, 16'h0100, 16'h0000);
    chk("rel_state", int'(state_out), 4);
    chk("rel_gain", int'(gain_out), 'h4000);
    apply(1, 1, 16'h0800, 16'h0000);
    chk("retrig_rel_state", int'(state_out), 1);
    chk("retrig_rel_gain", int'(gain_out), 'h4000);
    apply(1, 1, 16'h0800, 16'h0000);
    chk("retrig_rel_gain2", int'(gain_out), 'h4100);

    // datapath at full and at floor gain
    to_open();
    apply(1, 1, 16'h0500, 16'h4000);
    chk("dp_full_y", int'(y_out), 'h3FFF);
    chk("dp_full_valid", int'(y_valid), 1);
    apply(1, 0, 16'h0500, 16'h1234);
    chk("dp_idle_valid", int'(y_valid), 0);
    chk("dp_idle_y", int'(y_out), 'h3FFF);
    apply(0, 0, 0, 0);
    apply(1, 1, 16'h0000, 16'h8000);
    chk("dp_floor_y", int'(y_out), int'(16'(-F)));

    // reset mid-attack
    apply(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(1, 1, 16'h0500, 16'h0000);
    chk("mid_attack", int'(state_out), 1);
    apply(0, 1, 16'h0500, 16'h0000);
    chk("rst_state", int'(state_out), 0);
    chk("rst_gain", int'(gain_out), F);
    chk("rst_open", int'(gate_open), 0);
    apply(1, 1, 16'h0500, 16'h0000);
    chk("post_rst_state", int'(state_out), 1);
    chk("post_rst_gain", int'(gain_out), F);

    // random stimulus
    rv = '{16'h0100, 16'h01FF, 16'h0200, 16'h0300, 16'h03FF, 16'h0400, 16'h0800};
    apply(0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      apply($urandom_range(0, 499) != 0, 1'($urandom), rv[$urandom_range(0, 6)], 16'($urandom));
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
